// File: rtl/gnn_node_seq_if.sv
// Port bundle for one gnn_node_seq: input handshake, neighbour ReLU exchange and result handshake.
// A transfer happens on a rising clk edge where valid && ready; valid holds its payload until then.
interface gnn_node_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int N_NBR = 2,
  parameter int IN_W  = 6,
  parameter int W_W   = 5
);
  localparam int HID_W = IN_W + W_W + $clog2(N_IN);
  localparam int AGG_W = HID_W + $clog2(N_NBR + 1);
  localparam int OUT_W = AGG_W + W_W + $clog2(N_HID);

  logic                          in_valid;
  logic                          in_ready;
  logic [N_IN*IN_W-1:0]          x_flat;
  logic [N_IN*N_HID*W_W-1:0]     w_hid_flat;
  logic [N_HID*N_OUT*W_W-1:0]    w_out_flat;
  logic [N_HID*HID_W-1:0]        relu_out;
  logic                          relu_out_valid;
  logic [N_NBR*N_HID*HID_W-1:0]  nbr_relu;
  logic [N_NBR-1:0]              nbr_valid;
  logic [N_OUT*OUT_W-1:0]        out_flat;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;
  logic [2:0]                    state_dbg;

  modport master (
    output in_valid, x_flat, w_hid_flat, w_out_flat, nbr_relu, nbr_valid, out_ready,
    input  in_ready, relu_out, relu_out_valid, out_flat, out_valid, busy, state_dbg
  );

  modport slave (
    input  in_valid, x_flat, w_hid_flat, w_out_flat, nbr_relu, nbr_valid, out_ready,
    output in_ready, relu_out, relu_out_valid, out_flat, out_valid, busy, state_dbg
  );
endinterface

// File: rtl/gnn_node_seq.sv
// Time-multiplexed GNN node: x*W_hid -> ReLU -> aggregate with neighbours -> agg*W_out,
// one MAC per hidden unit and one per output unit, stepped by the k and j counters.
module gnn_node_seq #(
  parameter int N_IN     = 4,
  parameter int N_HID    = 4,
  parameter int N_OUT    = 2,
  parameter int N_NBR    = 2,
  parameter int IN_W     = 6,
  parameter int W_W      = 5,
  parameter int AGG_MODE = 0
) (
  input logic           clk,
  input logic           rst_n,
  gnn_node_seq_if.slave bus
);
  localparam int HID_W = IN_W + W_W + $clog2(N_IN);
  localparam int AGG_W = HID_W + $clog2(N_NBR + 1);
  localparam int OUT_W = AGG_W + W_W + $clog2(N_HID);
  localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW    = (N_HID > 1) ? $clog2(N_HID) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HIDDEN, S_RELU, S_AGG, S_OUTPUT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N_IN*IN_W-1:0]       x_q;
  logic [N_IN*N_HID*W_W-1:0]  wh_q;
  logic [N_HID*N_OUT*W_W-1:0] wo_q;
  logic [KW-1:0]              k_q;
  logic [JW-1:0]              j_q;

  logic signed [HID_W-1:0] acc_h  [N_HID];
  logic signed [HID_W-1:0] prod_h [N_HID];
  logic signed [HID_W-1:0] relu_q [N_HID];
  logic signed [AGG_W-1:0] agg_q  [N_HID];
  logic signed [AGG_W-1:0] agg_d  [N_HID];
  logic signed [OUT_W-1:0] acc_o  [N_OUT];
  logic signed [OUT_W-1:0] prod_o [N_OUT];
  logic signed [OUT_W-1:0] out_q  [N_OUT];
  logic                    relu_valid_q;
  logic                    out_valid_q;

  logic accept, nbr_all, last_k, last_j;

  assign accept  = bus.in_valid && bus.in_ready;
  assign nbr_all = &bus.nbr_valid;
  assign last_k  = (k_q == KW'(N_IN - 1));
  assign last_j  = (j_q == JW'(N_HID - 1));

  assign bus.in_ready       = rst_n && (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.state_dbg      = state_q;
  assign bus.relu_out_valid = relu_valid_q;
  assign bus.out_valid      = out_valid_q;

  for (genvar g = 0; g < N_HID; g++) begin : g_relu
    assign bus.relu_out[g*HID_W +: HID_W] = relu_q[g];
  end
  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign bus.out_flat[g*OUT_W +: OUT_W] = out_q[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept)  state_d = S_HIDDEN;
      S_HIDDEN: if (last_k)  state_d = S_RELU;
      S_RELU:                state_d = S_AGG;
      S_AGG:    if (nbr_all) state_d = S_OUTPUT;
      S_OUTPUT: if (last_j)  state_d = S_DONE;
      S_DONE:   if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Operands are sign-extended to the accumulator width before multiplying, so no product wraps.
  always_comb begin
    for (int j = 0; j < N_HID; j++) begin
      prod_h[j] = HID_W'($signed(x_q[int'(k_q)*IN_W +: IN_W]))
                * HID_W'($signed(wh_q[(int'(k_q)*N_HID + j)*W_W +: W_W]));
    end
    for (int m = 0; m < N_OUT; m++) begin
      prod_o[m] = OUT_W'(agg_q[j_q])
                * OUT_W'($signed(wo_q[(int'(j_q)*N_OUT + m)*W_W +: W_W]));
    end
  end

  always_comb begin
    logic signed [AGG_W-1:0] sum_v;
    logic signed [HID_W-1:0] max_v;
    logic signed [HID_W-1:0] nbr_v;
    sum_v = '0;
    max_v = '0;
    nbr_v = '0;
    for (int j = 0; j < N_HID; j++) begin
      sum_v = AGG_W'(relu_q[j]);
      max_v = relu_q[j];
      for (int n = 0; n < N_NBR; n++) begin
        nbr_v = $signed(bus.nbr_relu[(n*N_HID + j)*HID_W +: HID_W]);
        sum_v = sum_v + AGG_W'(nbr_v);
        if (nbr_v > max_v) max_v = nbr_v;
      end
      agg_d[j] = (AGG_MODE != 0) ? AGG_W'(max_v) : sum_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q          <= '0;
      wh_q         <= '0;
      wo_q         <= '0;
      k_q          <= '0;
      j_q          <= '0;
      relu_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      for (int j = 0; j < N_HID; j++) begin
        acc_h[j]  <= '0;
        relu_q[j] <= '0;
        agg_q[j]  <= '0;
      end
      for (int m = 0; m < N_OUT; m++) begin
        acc_o[m] <= '0;
        out_q[m] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          x_q  <= bus.x_flat;
          wh_q <= bus.w_hid_flat;
          wo_q <= bus.w_out_flat;
          k_q  <= '0;
          j_q  <= '0;
          for (int j = 0; j < N_HID; j++) acc_h[j] <= '0;
          for (int m = 0; m < N_OUT; m++) acc_o[m] <= '0;
        end
        S_HIDDEN: begin
          for (int j = 0; j < N_HID; j++) acc_h[j] <= acc_h[j] + prod_h[j];
          k_q <= last_k ? '0 : k_q + 1'b1;
        end
        S_RELU: begin
          for (int j = 0; j < N_HID; j++) relu_q[j] <= acc_h[j][HID_W-1] ? '0 : acc_h[j];
          relu_valid_q <= 1'b1;
        end
        S_AGG: if (nbr_all) begin
          for (int j = 0; j < N_HID; j++) agg_q[j] <= agg_d[j];
        end
        S_OUTPUT: begin
          for (int m = 0; m < N_OUT; m++) acc_o[m] <= acc_o[m] + prod_o[m];
          j_q <= last_j ? '0 : j_q + 1'b1;
          if (last_j) begin
            for (int m = 0; m < N_OUT; m++) out_q[m] <= acc_o[m] + prod_o[m];
            out_valid_q  <= 1'b1;
            relu_valid_q <= 1'b0;
          end
        end
        S_DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gnn_node_seq.sv
// Bench for gnn_node_seq: a sum-mode and a max-mode node driven in lockstep, checked against
// an arithmetic model of the node plus literal expectations for the directed cases.
module tb_gnn_node_seq;
  localparam int N_IN  = 4;
  localparam int N_HID = 4;
  localparam int N_OUT = 2;
  localparam int N_NBR = 2;
  localparam int IN_W  = 6;
  localparam int W_W   = 5;
  localparam int HID_W = IN_W + W_W + $clog2(N_IN);
  localparam int AGG_W = HID_W + $clog2(N_NBR + 1);
  localparam int OUT_W = AGG_W + W_W + $clog2(N_HID);
  localparam int BASE_LAT = N_IN + N_HID + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                         in_valid;
  logic                         out_ready;
  logic [N_IN*IN_W-1:0]         x_flat;
  logic [N_IN*N_HID*W_W-1:0]    w_hid_flat;
  logic [N_HID*N_OUT*W_W-1:0]   w_out_flat;
  logic [N_NBR*N_HID*HID_W-1:0] nbr_relu;
  logic [N_NBR-1:0]             nbr_valid;

  gnn_node_seq_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .N_NBR(N_NBR),
                    .IN_W(IN_W), .W_W(W_W)) bus_s ();
  gnn_node_seq_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .N_NBR(N_NBR),
                    .IN_W(IN_W), .W_W(W_W)) bus_m ();

  assign bus_s.in_valid = in_valid;    assign bus_m.in_valid = in_valid;
  assign bus_s.out_ready = out_ready;  assign bus_m.out_ready = out_ready;
  assign bus_s.x_flat = x_flat;        assign bus_m.x_flat = x_flat;
  assign bus_s.w_hid_flat = w_hid_flat; assign bus_m.w_hid_flat = w_hid_flat;
  assign bus_s.w_out_flat = w_out_flat; assign bus_m.w_out_flat = w_out_flat;
  assign bus_s.nbr_relu = nbr_relu;    assign bus_m.nbr_relu = nbr_relu;
  assign bus_s.nbr_valid = nbr_valid;  assign bus_m.nbr_valid = nbr_valid;

  gnn_node_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .N_NBR(N_NBR),
                 .IN_W(IN_W), .W_W(W_W), .AGG_MODE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  gnn_node_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .N_NBR(N_NBR),
                 .IN_W(IN_W), .W_W(W_W), .AGG_MODE(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // reference model: plain integer arithmetic over the node's rules
  int     xs   [N_IN];
  int     whs  [N_IN][N_HID];
  int     wos  [N_HID][N_OUT];
  int     nbrs [N_NBR][N_HID];
  int     m_relu  [N_HID];
  int     m_agg_s [N_HID];
  int     m_agg_m [N_HID];
  longint m_out_s [N_OUT];
  longint m_out_m [N_OUT];

  function automatic void model();
    for (int j = 0; j < N_HID; j++) begin
      longint h = 0;
      for (int k = 0; k < N_IN; k++) h += longint'(xs[k]) * whs[k][j];
      m_relu[j]  = (h < 0) ? 0 : int'(h);
      m_agg_s[j] = m_relu[j];
      m_agg_m[j] = m_relu[j];
      for (int n = 0; n < N_NBR; n++) begin
        m_agg_s[j] += nbrs[n][j];
        if (nbrs[n][j] > m_agg_m[j]) m_agg_m[j] = nbrs[n][j];
      end
    end
    for (int m = 0; m < N_OUT; m++) begin
      m_out_s[m] = 0;
      m_out_m[m] = 0;
      for (int j = 0; j < N_HID; j++) begin
        m_out_s[m] += longint'(m_agg_s[j]) * wos[j][m];
        m_out_m[m] += longint'(m_agg_m[j]) * wos[j][m];
      end
    end
  endfunction

  // scoreboard
  logic [N_OUT*OUT_W-1:0] exp_q  [$];
  logic [N_OUT*OUT_W-1:0] exp_qm [$];
  logic [N_HID*HID_W-1:0] exp_relu;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_s.relu_out_valid) check("relu_s", 64'(bus_s.relu_out), 64'(exp_relu));
      if (bus_m.relu_out_valid) check("relu_m", 64'(bus_m.relu_out), 64'(exp_relu));
      if (bus_s.out_valid) begin
        if (exp_q.size() == 0) flag("out_s_unexpected");
        else check("out_s", 64'(bus_s.out_flat), 64'(exp_q[0]));
      end
      if (bus_m.out_valid) begin
        if (exp_qm.size() == 0) flag("out_m_unexpected");
        else check("out_m", 64'(bus_m.out_flat), 64'(exp_qm[0]));
      end
      if (bus_s.out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus_m.out_valid && out_ready && exp_qm.size() > 0) void'(exp_qm.pop_front());
    end
  end

  // driver tasks
  task automatic pack_inputs();
    for (int k = 0; k < N_IN; k++) x_flat[k*IN_W +: IN_W] = IN_W'(xs[k]);
    for (int k = 0; k < N_IN; k++)
      for (int j = 0; j < N_HID; j++) w_hid_flat[(k*N_HID+j)*W_W +: W_W] = W_W'(whs[k][j]);
    for (int j = 0; j < N_HID; j++)
      for (int m = 0; m < N_OUT; m++) w_out_flat[(j*N_OUT+m)*W_W +: W_W] = W_W'(wos[j][m]);
    for (int n = 0; n < N_NBR; n++)
      for (int j = 0; j < N_HID; j++) nbr_relu[(n*N_HID+j)*HID_W +: HID_W] = HID_W'(nbrs[n][j]);
  endtask

  task automatic fill(input int xv, input int whv, input int wov, input int n0, input int n1);
    for (int k = 0; k < N_IN; k++) xs[k] = xv;
    for (int k = 0; k < N_IN; k++) for (int j = 0; j < N_HID; j++) whs[k][j] = whv;
    for (int j = 0; j < N_HID; j++) for (int m = 0; m < N_OUT; m++) wos[j][m] = wov;
    for (int n = 0; n < N_NBR; n++) for (int j = 0; j < N_HID; j++) nbrs[n][j] = (n == 0) ? n0 : n1;
  endtask

  task automatic rand_vals();
    for (int k = 0; k < N_IN; k++) xs[k] = int'($urandom_range(0, 63)) - 32;
    for (int k = 0; k < N_IN; k++)
      for (int j = 0; j < N_HID; j++) whs[k][j] = int'($urandom_range(0, 31)) - 16;
    for (int j = 0; j < N_HID; j++)
      for (int m = 0; m < N_OUT; m++) wos[j][m] = int'($urandom_range(0, 31)) - 16;
    for (int n = 0; n < N_NBR; n++)
      for (int j = 0; j < N_HID; j++) nbrs[n][j] = int'($urandom_range(0, 4095));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_qm.delete();
  endtask

  task automatic run_txn(input int stall, input int hold);
    logic [N_OUT*OUT_W-1:0] es, em;
    int cnt;
    pack_inputs();
    model();
    for (int m = 0; m < N_OUT; m++) begin
      es[m*OUT_W +: OUT_W] = OUT_W'(m_out_s[m]);
      em[m*OUT_W +: OUT_W] = OUT_W'(m_out_m[m]);
    end
    for (int j = 0; j < N_HID; j++) exp_relu[j*HID_W +: HID_W] = HID_W'(m_relu[j]);
    exp_q.push_back(es);
    exp_qm.push_back(em);
    check("in_ready_idle", 64'(bus_s.in_ready), 64'(1));
    nbr_valid = N_NBR'($urandom_range(0, (1 << N_NBR) - 2));
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_flat     = (N_IN*IN_W)'($urandom);
    w_hid_flat = (N_IN*N_HID*W_W)'({$urandom, $urandom, $urandom});
    w_out_flat = (N_HID*N_OUT*W_W)'({$urandom, $urandom});
    cnt = 0;
    while (!bus_s.out_valid && cnt < 100) begin
      if (cnt == N_IN + 1 + stall) nbr_valid = '1;
      @(posedge clk); #1;
      cnt++;
      check("relu_valid_window", 64'(bus_s.relu_out_valid),
            64'((cnt >= N_IN + 1) && (cnt < BASE_LAT + stall)));
    end
    if (!bus_s.out_valid) begin
      flag("timeout_out_valid");
      do_reset();
      return;
    end
    check("latency", 64'(cnt), 64'(BASE_LAT + stall));
    check("busy_done", 64'(bus_s.busy), 64'(1));
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      check("in_ready_done", 64'(bus_s.in_ready), 64'(0));
      check("out_valid_hold", 64'(bus_m.out_valid), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after", 64'(bus_s.in_ready), 64'(1));
    check("out_valid_after", 64'(bus_s.out_valid), 64'(0));
    check("busy_after", 64'(bus_m.busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    nbr_valid = '0;
    x_flat = '0;
    w_hid_flat = '0;
    w_out_flat = '0;
    nbr_relu = '0;
    exp_relu = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_relu_out", 64'(bus_s.relu_out), 64'(0));
    check("rst_out_flat", 64'(bus_s.out_flat), 64'(0));
    check("rst_out_valid", 64'(bus_s.out_valid), 64'(0));
    check("rst_relu_valid", 64'(bus_s.relu_out_valid), 64'(0));
    check("rst_in_ready_low", 64'(bus_s.in_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_rel", 64'(bus_s.in_ready), 64'(1));
    check("rst_busy", 64'(bus_s.busy), 64'(0));

    // all ones, neighbours 2 and 3
    fill(1, 1, 1, 2, 3);
    model();
    check("pin_t1_relu", 64'(m_relu[0]), 64'(4));
    check("pin_t1_agg", 64'(m_agg_s[1]), 64'(9));
    check("pin_t1_out", 64'(m_out_s[0]), 64'(36));
    run_txn(0, 0);

    // extreme negative operands, no wrap
    fill(-32, -16, -16, 2048, 2048);
    model();
    check("pin_t2_relu", 64'(m_relu[2]), 64'(2048));
    check("pin_t2_agg", 64'(m_agg_s[3]), 64'(6144));
    check("pin_t2_out", 64'(m_out_s[1]), 64'(-393216));
    run_txn(0, 1);

    // negative hidden unit clamps to 0, max aggregation picks the neighbour
    fill(31, 1, 1, 0, 0);
    for (int k = 0; k < N_IN; k++) whs[k][0] = -16;
    nbrs[0][0] = 7;
    nbrs[1][0] = 5;
    model();
    check("pin_t3_relu0", 64'(m_relu[0]), 64'(0));
    check("pin_t3_aggm0", 64'(m_agg_m[0]), 64'(7));
    check("pin_t3_outm", 64'(m_out_m[0]), 64'(379));
    run_txn(0, 0);

    // neighbour stall of 5 cycles
    fill(1, 1, 1, 2, 3);
    run_txn(5, 0);

    // downstream back-pressure with in_valid pulsed in DONE
    run_txn(0, 3);

    // reset while in HIDDEN at k=2
    pack_inputs();
    nbr_valid = '1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 64'(bus_s.busy), 64'(1));
    rst_n = 1'b0;
    exp_q.delete();
    exp_qm.delete();
    @(posedge clk); #1;
    check("mid_rst_relu", 64'(bus_s.relu_out), 64'(0));
    check("mid_rst_out", 64'(bus_m.out_flat), 64'(0));
    check("mid_rst_valids", 64'({bus_s.out_valid, bus_s.relu_out_valid}), 64'(0));
    check("mid_rst_busy", 64'(bus_s.busy), 64'(0));
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(bus_s.in_ready), 64'(1));
    fill(1, 1, 1, 2, 3);
    run_txn(0, 0);

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      rand_vals();
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size() + exp_qm.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
